// File: rtl/pc_fetch_ctrl.sv
// IF-stage fetch-PC generator: valid/ready fetch handshake, prioritised redirects, misaligned-target trap.
// Optional MIPS branch delay slot is enabled by defining PC_FETCH_DELAY_SLOT_EN.
module pc_fetch_ctrl #(
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(32'hBFC00000),
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(32'hBFC00380),
  parameter int unsigned       INC          = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  output logic              fetch_valid,
  input  logic              fetch_ready,
  output logic [ADDR_W-1:0] fetch_pc,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              exc_valid,
  input  logic              eret_valid,
  input  logic [ADDR_W-1:0] eret_pc,
  output logic              flush,
  output logic              addr_err,
  output logic [ADDR_W-1:0] badvaddr,
  output logic              redir_pending
);

  // Encoding doubles as priority: a larger value wins.
  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_BR   = 2'd1,
    KIND_ERET = 2'd2,
    KIND_EXC  = 2'd3
  } redir_kind_e;

  logic [ADDR_W-1:0] r_pc;
  logic              r_valid;
  logic              r_flush;
  logic              r_addr_err;
  logic [ADDR_W-1:0] r_badvaddr;
  logic              r_pend_valid;
  redir_kind_e       r_pend_kind;
  logic [ADDR_W-1:0] r_pend_target;

  logic              w_fire;
  redir_kind_e       w_in_kind;
  logic [ADDR_W-1:0] w_in_target;
  redir_kind_e       w_pend_kind;
  logic              w_take_in;
  logic              w_misaligned;
  redir_kind_e       w_eff_kind;
  logic [ADDR_W-1:0] w_eff_target;
  logic              w_has_redir;
  logic              w_delay;

  assign w_fire      = r_valid & fetch_ready & ~stall;
  assign w_pend_kind = r_pend_valid ? r_pend_kind : KIND_NONE;

  // Pick the highest-priority incoming request.
  always_comb begin
    w_in_kind   = KIND_NONE;
    w_in_target = '0;
    if (exc_valid) begin
      w_in_kind   = KIND_EXC;
      w_in_target = EXC_VECTOR;
    end else if (eret_valid) begin
      w_in_kind   = KIND_ERET;
      w_in_target = eret_pc;
    end else if (br_valid) begin
      w_in_kind   = KIND_BR;
      w_in_target = br_target;
    end else begin
      w_in_kind   = KIND_NONE;
      w_in_target = '0;
    end
  end

  // Pending redirect yields only to strictly higher incoming priority, except a newer branch replaces an older one.
  always_comb begin
    w_take_in    = 1'b0;
    w_misaligned = 1'b0;
    w_eff_kind   = w_pend_kind;
    w_eff_target = r_pend_target;
    if (w_in_kind != KIND_NONE &&
        ((w_in_kind > w_pend_kind) || (w_in_kind == KIND_BR && w_pend_kind == KIND_BR))) begin
      w_take_in    = 1'b1;
      w_misaligned = (w_in_kind != KIND_EXC) && (w_in_target[1:0] != 2'b00);
      if (w_misaligned) begin
        w_eff_kind   = KIND_EXC;
        w_eff_target = EXC_VECTOR;
      end else begin
        w_eff_kind   = w_in_kind;
        w_eff_target = w_in_target;
      end
    end else begin
      w_take_in    = 1'b0;
      w_misaligned = 1'b0;
    end
  end

  assign w_has_redir = (w_eff_kind != KIND_NONE);

`ifdef PC_FETCH_DELAY_SLOT_EN
  logic r_skip;
  logic w_new_branch;

  // A branch owes one sequential fetch (its delay slot) before its target is applied.
  assign w_new_branch = w_take_in & ~w_misaligned & (w_in_kind == KIND_BR);
  assign w_delay      = (w_eff_kind == KIND_BR) & (w_new_branch | r_skip);

  // Skip flag: armed by a fresh branch that is captured, cleared by any fire or a higher redirect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_skip <= 1'b0;
    end else if (w_fire) begin
      r_skip <= 1'b0;
    end else if (w_has_redir) begin
      r_skip <= w_delay;
    end else begin
      r_skip <= r_skip;
    end
  end
`else
  assign w_delay = 1'b0;
`endif

  // Fetch PC, pending slot and status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc          <= RESET_VECTOR;
      r_valid       <= 1'b0;
      r_flush       <= 1'b0;
      r_addr_err    <= 1'b0;
      r_badvaddr    <= '0;
      r_pend_valid  <= 1'b0;
      r_pend_kind   <= KIND_NONE;
      r_pend_target <= '0;
    end else begin
      r_valid    <= 1'b1;
      r_flush    <= 1'b0;
      r_addr_err <= w_misaligned;
      if (w_misaligned) begin
        r_badvaddr <= w_in_target;
      end else begin
        r_badvaddr <= r_badvaddr;
      end
      if (w_fire) begin
        if (w_has_redir && !w_delay) begin
          r_pc          <= w_eff_target;
          r_pend_valid  <= 1'b0;
          r_pend_kind   <= KIND_NONE;
          r_pend_target <= r_pend_target;
          r_flush       <= 1'b1;
        end else begin
          // Sequential advance; a delayed branch stays parked behind its delay slot.
          r_pc          <= r_pc + ADDR_W'(INC);
          r_pend_valid  <= w_delay;
          r_pend_kind   <= w_delay ? KIND_BR : KIND_NONE;
          r_pend_target <= w_eff_target;
        end
      end else if (w_has_redir) begin
        r_pend_valid  <= 1'b1;
        r_pend_kind   <= w_eff_kind;
        r_pend_target <= w_eff_target;
      end else begin
        r_pend_valid  <= r_pend_valid;
        r_pend_kind   <= r_pend_kind;
        r_pend_target <= r_pend_target;
      end
    end
  end

  assign fetch_valid   = r_valid;
  assign fetch_pc      = r_pc;
  assign flush         = r_flush;
  assign addr_err      = r_addr_err;
  assign badvaddr      = r_badvaddr;
  assign redir_pending = r_pend_valid;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: a priority-rule reference model queues expected per-cycle outputs,
// a monitor compares them on the falling edge; directed scenarios add literal spot checks.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RV = 32'hBFC00000;
  localparam logic [31:0] EV = 32'hBFC00380;
`ifdef PC_FETCH_DELAY_SLOT_EN
  localparam bit DS_EN = 1'b1;
`else
  localparam bit DS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic        br_valid;
  logic [31:0] br_target;
  logic        exc_valid;
  logic        eret_valid;
  logic [31:0] eret_pc;
  logic        flush;
  logic        addr_err;
  logic [31:0] badvaddr;
  logic        redir_pending;

  pc_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
    .br_valid(br_valid), .br_target(br_target),
    .exc_valid(exc_valid), .eret_valid(eret_valid), .eret_pc(eret_pc),
    .flush(flush), .addr_err(addr_err), .badvaddr(badvaddr), .redir_pending(redir_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        fl;
    logic        ae;
    logic [31:0] bad;
    logic        rp;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state: priorities are plain integers (branch 1, eret 2, exception 3).
  logic [31:0] m_pc, m_pt, m_bad;
  bit          m_valid, m_pv, m_skip, m_fl, m_ae;
  int          m_pp;

  task automatic model_reset();
    m_pc = RV; m_valid = 1'b0; m_pv = 1'b0; m_pp = 0; m_pt = 32'd0;
    m_skip = 1'b0; m_fl = 1'b0; m_ae = 1'b0; m_bad = 32'd0;
  endtask

  task automatic model_step(input bit st, input bit rd, input bit br, input logic [31:0] bt,
                            input bit ex, input bit er, input logic [31:0] ep);
    int          req_p, win_p;
    logic [31:0] req_t, win_t;
    bit          fire, fresh_br, hold_ds;
    fire  = m_valid && rd && !st;
    req_p = 0; req_t = 32'd0;
    if (br) begin req_p = 1; req_t = bt; end
    if (er) begin req_p = 2; req_t = ep; end
    if (ex) begin req_p = 3; req_t = EV; end
    m_fl = 1'b0; m_ae = 1'b0; fresh_br = 1'b0;
    win_p = m_pv ? m_pp : 0;
    win_t = m_pt;
    if (req_p > win_p || (req_p == 1 && win_p == 1)) begin
      win_p = req_p; win_t = req_t;
      if (req_p != 3 && req_t[1:0] != 2'b00) begin
        m_ae = 1'b1; m_bad = req_t; win_p = 3; win_t = EV;
      end else begin
        fresh_br = (req_p == 1);
      end
    end
    hold_ds = DS_EN && (win_p == 1) && (fresh_br || m_skip);
    if (fire) begin
      if (win_p != 0 && !hold_ds) begin
        m_pc = win_t; m_pv = 1'b0; m_fl = 1'b1;
      end else begin
        m_pc = m_pc + 32'd4; m_pv = hold_ds; m_pp = 1; m_pt = win_t;
      end
      m_skip = 1'b0;
    end else if (win_p != 0) begin
      m_pv = 1'b1; m_pp = win_p; m_pt = win_t; m_skip = hold_ds;
    end
    m_valid = 1'b1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input bit st, input bit rd, input bit br, input logic [31:0] bt,
                       input bit ex, input bit er, input logic [31:0] ep);
    exp_t e;
    stall = st; fetch_ready = rd; br_valid = br; br_target = bt;
    exc_valid = ex; eret_valid = er; eret_pc = ep;
    model_step(st, rd, br, bt, ex, er, ep);
    e.pc = m_pc; e.fl = m_fl; e.ae = m_ae; e.bad = m_bad; e.rp = m_pv;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_pc"}, fetch_pc, RV);
    chk({tag, "_valid"}, 32'(fetch_valid), 32'd0);
    chk({tag, "_flush"}, 32'(flush), 32'd0);
    chk({tag, "_addr_err"}, 32'(addr_err), 32'd0);
    chk({tag, "_badvaddr"}, badvaddr, 32'd0);
    chk({tag, "_pending"}, 32'(redir_pending), 32'd0);
  endtask

  // Monitor: every cycle the DUT presents a fetch, compare against the oldest expected entry.
  always @(negedge clk) begin
    if (fetch_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_underflow: DUT presented pc=%h with no expected entry", fetch_pc);
      end else begin
        mon_e = exp_q.pop_front();
        if (fetch_pc === mon_e.pc && flush === mon_e.fl && addr_err === mon_e.ae &&
            badvaddr === mon_e.bad && redir_pending === mon_e.rp) begin
          n_pass++;
        end else begin
          $display("FAIL sb_cycle: got pc=%h flush=%b addr_err=%b badvaddr=%h pending=%b expected pc=%h flush=%b addr_err=%b badvaddr=%h pending=%b",
                   fetch_pc, flush, addr_err, badvaddr, redir_pending,
                   mon_e.pc, mon_e.fl, mon_e.ae, mon_e.bad, mon_e.rp);
        end
      end
    end
  end

  initial begin
    logic [31:0] t;
    rst_n = 1'b0; stall = 1'b0; fetch_ready = 1'b1; br_valid = 1'b0; br_target = 32'd0;
    exc_valid = 1'b0; eret_valid = 1'b0; eret_pc = 32'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst_n = 1'b1;

    // Sequential fetch out of reset.
    idle(); chk("t1_pc0", fetch_pc, 32'hBFC00000); chk("t1_valid", 32'(fetch_valid), 32'd1);
    idle(); chk("t1_pc1", fetch_pc, 32'hBFC00004);
    idle(); chk("t1_pc2", fetch_pc, 32'hBFC00008);

    // Branch captured during a stall, applied at the first fire after it.
    drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 32'h80001000, 1'b0, 1'b0, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("t2_hold_pc", fetch_pc, 32'hBFC00008);
    chk("t2_pending", 32'(redir_pending), 32'd1);
    idle();
`ifdef PC_FETCH_DELAY_SLOT_EN
    chk("t2_delay_slot_pc", fetch_pc, 32'hBFC0000C);
    idle();
`endif
    chk("t2_target_pc", fetch_pc, 32'h80001000);
    chk("t2_flush", 32'(flush), 32'd1);

    // Exception beats a simultaneous branch; the branch is dropped.
    drive(1'b0, 1'b1, 1'b1, 32'h80002000, 1'b1, 1'b0, 32'd0);
    chk("t3_exc_pc", fetch_pc, EV);
    chk("t3_flush", 32'(flush), 32'd1);
    idle();
    chk("t3_next_pc", fetch_pc, 32'hBFC00384);
    chk("t3_flush_once", 32'(flush), 32'd0);

    // Misaligned branch target traps to the exception vector.
    drive(1'b0, 1'b1, 1'b1, 32'h80000002, 1'b0, 1'b0, 32'd0);
    chk("t4_trap_pc", fetch_pc, EV);
    chk("t4_badvaddr", badvaddr, 32'h80000002);
    chk("t4_addr_err", 32'(addr_err), 32'd1);
    idle();
    chk("t4_addr_err_pulse", 32'(addr_err), 32'd0);

    // Pending branch displaced by a later eret.
    drive(1'b0, 1'b0, 1'b1, 32'h80003000, 1'b0, 1'b0, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'h80004000);
    chk("t5_eret_pc", fetch_pc, 32'h80004000);
    idle();
    chk("t5_branch_dropped", fetch_pc, 32'h80004004);
    chk("t5_pending_clear", 32'(redir_pending), 32'd0);

    // Branch from 80000000: delay slot first when enabled, else straight to target.
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'h80000000);
    drive(1'b0, 1'b1, 1'b1, 32'h90000000, 1'b0, 1'b0, 32'd0);
`ifdef PC_FETCH_DELAY_SLOT_EN
    chk("t6_slot_pc", fetch_pc, 32'h80000004);
    chk("t6_slot_no_flush", 32'(flush), 32'd0);
    idle();
`endif
    chk("t6_target_pc", fetch_pc, 32'h90000000);
    chk("t6_flush", 32'(flush), 32'd1);

    // Address wraps modulo 2^32.
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'hFFFFFFFC);
    idle();
    chk("wrap_pc", fetch_pc, 32'h00000000);

    // Randomised traffic, checked by the scoreboard only.
    for (int i = 0; i < 1500; i++) begin
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 4) == 0, t,
            $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
            ($urandom_range(0, 3) == 0) ? (t | 32'd1) : t);
    end

    // Reset mid-operation with a redirect pending discards it.
    drive(1'b0, 1'b0, 1'b1, 32'h80005000, 1'b0, 1'b0, 32'd0);
    chk("midrst_pending_before", 32'(redir_pending), 32'd1);
    rst_n = 1'b0; stall = 1'b0; fetch_ready = 1'b1; br_valid = 1'b0;
    exc_valid = 1'b0; eret_valid = 1'b0;
    @(posedge clk); #1;
    check_reset_state("midrst");
    model_reset();
    rst_n = 1'b1;
    idle(); chk("midrst_first_pc", fetch_pc, RV);
    for (int i = 0; i < 200; i++) begin
      t = $urandom & 32'hFFFFFFFC;
      drive($urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 3) == 0, t, $urandom_range(0, 24) == 0,
            $urandom_range(0, 9) == 0, t ^ 32'h00000100);
    end

    @(negedge clk); #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL sb_drain: got %0d unconsumed entries expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
